alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single ALU between two requesters, port 0 (execute stage) and port 1 (branch/PC-offset unit).
- Accepts one operation at a time and arbitrates round-robin.
- Registers the operands and drives the ALU control inputs (op1, op2, imm, is_add, is_addi).
- Captures the ALU result and returns it with a tag to the requester that was granted, using a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width of operands and result.
- TAG_W, 4, width of the requester-supplied transaction tag returned with the result.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request valid, N = 0, 1.
- reqN_ready  out  1  request accepted when reqN_valid and reqN_ready are both high.
- reqN_op1  in  XLEN  first operand.
- reqN_op2  in  XLEN  second operand.
- reqN_imm  in  XLEN  immediate.
- reqN_is_add  in  1  selects op1 + op2.
- reqN_is_addi  in  1  selects op1 + imm.
- reqN_tag  in  TAG_W  transaction tag.
- rspN_valid  out  1  response valid.
- rspN_ready  in  1  response consumed when rspN_valid and rspN_ready are both high.
- rspN_result  out  XLEN  result.
- rspN_tag  out  TAG_W  echoed tag.
- rspN_err  out  1  illegal-op flag.
- alu_op1  out  XLEN  ALU operand 1.
- alu_op2  out  XLEN  ALU operand 2.
- alu_imm  out  XLEN  ALU immediate.
- alu_is_add  out  1  ALU add select.
- alu_is_addi  out  1  ALU addi select.
- alu_reset  out  1  ALU reset, equal to reset.
- alu_result  in  XLEN  combinational ALU result.

Behaviour:
- Reset: all state is updated on the clk rising edge.
  - reset=1 forces state to IDLE and the priority pointer to 0.
  - All reqN_ready, rspN_valid, rspN_result, rspN_tag, rspN_err and all alu_* outputs are 0, except alu_reset=1.
- FSM with three states:
  - IDLE: req0_ready = req1_ready = 1 only when the arbiter selects that port. Exactly one ready is high, and only when a request is present; neither is high if no request is valid.
  - On an accepted request: capture op1, op2, imm, flags, tag and the granted port index, then go to ISSUE.
  - ISSUE (one cycle): drive alu_* from the captured registers; all other cycles drive alu_* to 0. At the end of the cycle, capture alu_result into the response register and go to RESP.
  - RESP: assert rspG_valid for the granted port G only. Hold result, tag and err stable until rspG_ready=1, then return to IDLE.
- Latency and throughput:
  - Request accepted at edge N: response valid from cycle N+2.
  - Minimum 3 cycles per operation.
  - Requests are never accepted in ISSUE or RESP; reqN_ready=0 in those states.
- Arbitration: round-robin with a 1-bit priority pointer `prio`.
  - Both valid: grant port `prio`.
  - One valid: grant that port.
  - After any grant, `prio` = opposite of the granted port.
  - No grant: `prio` unchanged.
  - A request held valid while the other port is granted is accepted on the next IDLE; there is no starvation.
- Op legality:
  - is_add=1, is_addi=0: drive alu_is_add=1; err=0.
  - is_addi=1, is_add=0: drive alu_is_addi=1; err=0.
  - Both set: drive is_add only; result = op1 + op2; err=1.
  - Neither set: the ALU is not driven (flags 0); result = 0; err=1. The response is still returned.
- Width: the result is XLEN bits and overflow wraps modulo 2^XLEN; for example 0xFFFFFFFF + 1 = 0x00000000.
- Requester contract: requesters must hold payload stable while valid and not ready. The block samples payload only at the accept edge.
- Simultaneous events: a rspG_ready seen in the same cycle the response is presented completes the handshake that cycle.
- Reset mid-operation: any captured op in ISSUE or RESP is discarded and no response is produced. `prio` returns to 0.

Test Plan:
1. Reset held 2 cycles, then released; no valid requests -> all outputs 0 (alu_reset=1 during reset, 0 after), both readys 0, state stays IDLE.
2. Port 0 single add: op1=2, op2=1, is_add=1, tag=3, accepted at edge N; rsp0_ready=1 -> alu_is_add=1 with op1=2, op2=1 in cycle N+1; rsp0_valid in cycle N+2 with result=3, tag=3, err=0; rsp1_valid stays 0.
3. Both ports valid every cycle, always ready: port 0 addi (op1=1, imm=2), port 1 add (op1=5, op2=7) -> grants 0,1,0,1 (first after reset to port 0); results 3 and 12 on the matching ports; one accept every 3 cycles.
4. Backpressure: hold rsp1_ready=0 for 5 cycles after rsp1_valid rises -> result, tag and valid stay stable; req0_ready stays 0 throughout; IDLE re-entered the cycle after rsp1_ready=1.
5. Illegal and wrap ops:
   - Both flags set, op1=0xFFFFFFFF, op2=1 -> result 0x00000000, err=1.
   - Neither flag set -> result 0, err=1, alu_is_add and alu_is_addi remain 0 in ISSUE.
6. Reset asserted in RESP with rsp0_ready=0 -> next cycle rsp0_valid=0, the op is lost, `prio`=0; a new port 1 request is then accepted normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter that time-shares one combinational ALU.
// Each accepted op runs IDLE -> ISSUE -> RESP; the result is returned with its tag over valid/ready.
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_op1,
    input  logic [XLEN-1:0]  req0_op2,
    input  logic [XLEN-1:0]  req0_imm,
    input  logic             req0_is_add,
    input  logic             req0_is_addi,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_op1,
    input  logic [XLEN-1:0]  req1_op2,
    input  logic [XLEN-1:0]  req1_imm,
    input  logic             req1_is_add,
    input  logic             req1_is_addi,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_result,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_result,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             rsp1_err,

    output logic [XLEN-1:0]  alu_op1,
    output logic [XLEN-1:0]  alu_op2,
    output logic [XLEN-1:0]  alu_imm,
    output logic             alu_is_add,
    output logic             alu_is_addi,
    output logic             alu_reset,
    input  logic [XLEN-1:0]  alu_result
);

    // state   | meaning
    // S_IDLE  | waiting for a request; ready raised on the arbitrated port
    // S_ISSUE | captured operands drive the ALU for one cycle
    // S_RESP  | result held on the granted port until consumed
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_gnt;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_imm;
    logic              r_is_add;
    logic              r_is_addi;
    logic              r_err;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_result;

    logic              w_any;
    logic              w_gnt_port;
    logic              w_rsp_ready;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic [XLEN-1:0]   w_imm;
    logic              w_is_add;
    logic              w_is_addi;
    logic [TAG_W-1:0]  w_tag;

    assign w_any       = req0_valid | req1_valid;
    assign w_gnt_port  = (req0_valid & req1_valid) ? r_prio : req1_valid;
    assign w_rsp_ready = r_gnt ? rsp1_ready : rsp0_ready;

    assign w_op1     = w_gnt_port ? req1_op1     : req0_op1;
    assign w_op2     = w_gnt_port ? req1_op2     : req0_op2;
    assign w_imm     = w_gnt_port ? req1_imm     : req0_imm;
    assign w_is_add  = w_gnt_port ? req1_is_add  : req0_is_add;
    assign w_is_addi = w_gnt_port ? req1_is_addi : req0_is_addi;
    assign w_tag     = w_gnt_port ? req1_tag     : req0_tag;

    assign alu_reset = reset;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_is_add  <= 1'b0;
            r_is_addi <= 1'b0;
            r_err     <= 1'b0;
            r_tag     <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_gnt     <= w_gnt_port;
                r_prio    <= ~w_gnt_port;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_imm     <= w_imm;
                // Both flags set degrades to a plain add; either way the op is flagged.
                r_is_add  <= w_is_add;
                r_is_addi <= w_is_addi & ~w_is_add;
                r_err     <= ~(w_is_add ^ w_is_addi);
                r_tag     <= w_tag;
            end
            if (r_state == S_ISSUE) begin
                // With no flag the ALU output is meaningless, so report zero.
                r_result <= (r_is_add | r_is_addi) ? alu_result : '0;
            end
        end
    end

    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp0_result = '0;
        rsp0_tag    = '0;
        rsp0_err    = 1'b0;
        rsp1_valid  = 1'b0;
        rsp1_result = '0;
        rsp1_tag    = '0;
        rsp1_err    = 1'b0;
        alu_op1     = '0;
        alu_op2     = '0;
        alu_imm     = '0;
        alu_is_add  = 1'b0;
        alu_is_addi = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    req0_ready = w_any & ~w_gnt_port;
                    req1_ready = w_any &  w_gnt_port;
                end
                S_ISSUE: begin
                    alu_op1     = r_op1;
                    alu_op2     = r_op2;
                    alu_imm     = r_imm;
                    alu_is_add  = r_is_add;
                    alu_is_addi = r_is_addi;
                end
                S_RESP: begin
                    if (r_gnt) begin
                        rsp1_valid  = 1'b1;
                        rsp1_result = r_result;
                        rsp1_tag    = r_tag;
                        rsp1_err    = r_err;
                    end else begin
                        rsp0_valid  = 1'b1;
                        rsp0_result = r_result;
                        rsp0_tag    = r_tag;
                        rsp0_err    = r_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
